// File: rtl/rmii_send_frame.sv
// Ethernet frame sequencer for an RMII byte serializer: preamble, SFD, buffered data,
// zero padding, on-the-fly CRC-32 FCS, then the interframe gap.
module rmii_send_frame #(
    parameter int ADDR_W   = 11,
    parameter int MIN_LEN  = 60,
    parameter int MAX_LEN  = 1514,
    parameter int IFG_FAST = 96,
    parameter int IFG_SLOW = 960
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fast_eth,
    input  logic [ADDR_W-1:0] frame_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              done
);

    localparam int IFG_MAX = (IFG_FAST > IFG_SLOW) ? IFG_FAST : IFG_SLOW;
    localparam int IFG_W   = $clog2(IFG_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DRAIN, ST_IFG
    } state_t;

    state_t             state_q, state_d;
    logic               tx_rdy_q;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        crc_q, crc_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic               fast_q, fast_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;

    // Reflected CRC-32 (poly EDB88320), one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic               accept;
    logic [ADDR_W-1:0]  cnt_inc;
    logic [ADDR_W-1:0]  addr_inc;
    logic [ADDR_W-1:0]  len_eff;
    logic               last_pre, last_data, last_pad, last_fcs, pad_needed, ifg_zero;
    logic [31:0]        crc_upd;
    logic [31:0]        fcs_w;
    logic [7:0]         fcs_next;

    assign accept     = tx_rdy_q & ~tx_rdy;
    assign cnt_inc    = cnt_q + 1'b1;
    assign addr_inc   = rd_addr_q + 1'b1;
    assign len_eff    = (frame_len > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : frame_len;
    assign last_pre   = (cnt_q == ADDR_W'(6));
    assign last_data  = (cnt_inc == len_q);
    assign last_pad   = (cnt_inc == ADDR_W'(MIN_LEN));
    assign last_fcs   = (cnt_q == ADDR_W'(3));
    assign pad_needed = (len_q < ADDR_W'(MIN_LEN));
    assign ifg_zero   = (ifg_q == '0);
    assign crc_upd    = crc_byte(crc_q, tx_data_q);
    assign fcs_w      = ~crc_q;

    always_comb begin
        case (cnt_inc[1:0])
            2'd1:    fcs_next = fcs_w[15:8];
            2'd2:    fcs_next = fcs_w[23:16];
            2'd3:    fcs_next = fcs_w[31:24];
            default: fcs_next = fcs_w[7:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_rdy_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_q      <= 32'hFFFFFFFF;
            cnt_q      <= '0;
            len_q      <= '0;
            fast_q     <= 1'b0;
            ifg_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_rdy_q   <= tx_rdy;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            fast_q     <= fast_d;
            ifg_q      <= ifg_d;
        end
    end

    // NOTE: each always_comb assigns a default to every output first, so no path
    // can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_PRE;
            ST_PRE:   if (accept && last_pre) state_d = ST_SFD;
            ST_SFD:   if (accept) state_d = (len_q == '0) ? ST_PAD : ST_DATA;
            ST_DATA:  if (accept && last_data) state_d = pad_needed ? ST_PAD : ST_FCS;
            ST_PAD:   if (accept && last_pad) state_d = ST_FCS;
            ST_FCS:   if (accept && last_fcs) state_d = ST_DRAIN;
            ST_DRAIN: if (tx_rdy) state_d = ST_IFG;
            ST_IFG:   if (ifg_zero) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        rd_addr_d  = rd_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        fast_d     = fast_q;
        ifg_d      = ifg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = len_eff;
                    fast_d     = fast_eth;
                    busy_d     = 1'b1;
                    rd_addr_d  = '0;
                    crc_d      = 32'hFFFFFFFF;
                    cnt_d      = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h55;
                end
            end
            ST_PRE: begin
                if (accept) begin
                    cnt_d = last_pre ? '0 : cnt_inc;
                    if (last_pre) tx_data_d = 8'hD5;
                end
            end
            ST_SFD: begin
                // rd_addr has sat at 0 since start, so rd_data already holds byte 0.
                if (accept) begin
                    if (len_q == '0) begin
                        tx_data_d = 8'h00;
                    end else begin
                        tx_data_d = rd_data;
                        if (len_q > ADDR_W'(1)) rd_addr_d = ADDR_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    crc_d = crc_upd;
                    if (!last_data) begin
                        cnt_d     = cnt_inc;
                        tx_data_d = rd_data;
                        if (addr_inc < len_q) rd_addr_d = addr_inc;
                    end else if (pad_needed) begin
                        cnt_d     = cnt_inc;
                        tx_data_d = 8'h00;
                    end else begin
                        cnt_d     = '0;
                        tx_data_d = ~crc_upd[7:0];
                    end
                end
            end
            ST_PAD: begin
                if (accept) begin
                    crc_d = crc_upd;
                    if (last_pad) begin
                        cnt_d     = '0;
                        tx_data_d = ~crc_upd[7:0];
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_FCS: begin
                if (accept) begin
                    if (last_fcs) begin
                        cnt_d      = '0;
                        tx_start_d = 1'b0;
                    end else begin
                        cnt_d     = cnt_inc;
                        tx_data_d = fcs_next;
                    end
                end
            end
            ST_DRAIN: begin
                if (tx_rdy) ifg_d = fast_q ? IFG_W'(IFG_FAST - 1) : IFG_W'(IFG_SLOW - 1);
            end
            ST_IFG: begin
                if (ifg_zero) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    ifg_d = ifg_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rd_addr  = rd_addr_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rmii_send_frame.sv
// Bench for rmii_send_frame: buffer RAM and serializer models, expected byte stream queued
// at each start and compared by the serializer-side monitor as bytes are accepted.
module tb_rmii_send_frame;

    localparam int ADDR_W   = 11;
    localparam int MIN_LEN  = 60;
    localparam int MAX_LEN  = 1514;
    localparam int IFG_FAST = 96;
    localparam int IFG_SLOW = 960;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              fast_eth = 1'b0;
    logic [ADDR_W-1:0] frame_len = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_rdy;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    rmii_send_frame #(
        .ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN),
        .IFG_FAST(IFG_FAST), .IFG_SLOW(IFG_SLOW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .fast_eth(fast_eth),
        .frame_len(frame_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]        mem [0:2047];
    logic [7:0]        sb [$];
    int                nbytes;
    int                total_exp;
    int                ser_period = 8;
    int                timer = 0;
    int                rdy_cyc = 0;
    logic [31:0]       rx_crc;
    logic              gap_seen;
    logic              frame_active = 1'b0;
    logic [ADDR_W-1:0] max_addr;
    logic [ADDR_W-1:0] exp_max_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    always @(posedge clk) cyc++;

    // Buffer RAM: one cycle read latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    // Serializer model and scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            tx_rdy = 1'b1;
            timer  = 0;
        end else if (tx_rdy) begin
            if (tx_start) begin
                if (sb.size() == 0) check("sb_extra_byte", sb.size(), 1);
                else check($sformatf("stream_byte_%0d", nbytes), {24'd0, tx_data}, {24'd0, sb.pop_front()});
                if (nbytes >= 8) rx_crc = crc_byte(rx_crc, tx_data);
                nbytes++;
                tx_rdy = 1'b0;
                timer  = ser_period;
            end
        end else begin
            timer--;
            if (timer == 0) begin
                tx_rdy  = 1'b1;
                rdy_cyc = cyc;
            end
        end
        if (busy && frame_active && !tx_start && nbytes < total_exp) gap_seen = 1'b1;
        if (busy && frame_active && rd_addr > max_addr) max_addr = rd_addr;
    end

    // Called at a negedge: queue the expected stream, then pulse start for one cycle.
    task automatic start_frame(input int len, input bit fast, input logic [7:0] seed);
        int          l;
        int          body;
        logic [31:0] crc;
        logic [7:0]  b;
        l    = (len > MAX_LEN) ? MAX_LEN : len;
        body = (l < MIN_LEN) ? MIN_LEN : l;
        for (int i = 0; i < 2048; i++) mem[i] = i[7:0] ^ seed;
        for (int k = 0; k < 7; k++) sb.push_back(8'h55);
        sb.push_back(8'hD5);
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < body; k++) begin
            b = (k < l) ? mem[k] : 8'h00;
            sb.push_back(b);
            crc = crc_byte(crc, b);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) sb.push_back(crc[8*k +: 8]);
        total_exp    = 8 + body + 4;
        exp_max_addr = (l == 0) ? '0 : ADDR_W'(l - 1);
        nbytes       = 0;
        rx_crc       = 32'hFFFFFFFF;
        gap_seen     = 1'b0;
        max_addr     = '0;
        ser_period   = fast ? 8 : 80;
        frame_active = 1'b1;
        fast_eth     = fast;
        frame_len    = len[ADDR_W-1:0];
        start        = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        frame_len = ADDR_W'(3);
        fast_eth  = ~fast;
        check("preamble_started", {31'd0, tx_start}, 1);
        check("busy_after_start", {31'd0, busy}, 1);
    endtask

    task automatic wait_bytes(input int n);
        int i;
        i = 0;
        while (nbytes < n && i < 20000) begin
            @(negedge clk);
            i++;
        end
        check("wait_bytes", {31'd0, nbytes >= n}, 1);
    endtask

    // done must rise exactly ifg edges after the first edge that samples tx_rdy high.
    task automatic finish_frame(input int ifg);
        int i;
        i = 0;
        while (!done && i < 40000) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", {31'd0, done}, 1);
        check("ifg_cycles", cyc - rdy_cyc - 1, ifg);
        check("busy_low_at_done", {31'd0, busy}, 0);
        check("tx_start_low_at_done", {31'd0, tx_start}, 0);
        check("byte_count", nbytes, total_exp);
        check("sb_empty", sb.size(), 0);
        check("fcs_residue", rx_crc, 32'hDEBB20E3);
        check("tx_start_gapless", {31'd0, gap_seen}, 0);
        check("max_rd_addr", {21'd0, max_addr}, {21'd0, exp_max_addr});
        frame_active = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_rd_addr", {21'd0, rd_addr}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        start_frame(100, 1'b1, 8'h00);
        finish_frame(IFG_FAST);

        start_frame(10, 1'b1, 8'h00);
        finish_frame(IFG_FAST);

        start_frame(0, 1'b1, 8'h00);
        finish_frame(IFG_FAST);

        start_frame(2000, 1'b1, 8'hA5);
        finish_frame(IFG_FAST);

        start_frame(100, 1'b0, 8'h00);
        finish_frame(IFG_SLOW);

        // A start while busy must leave the running frame untouched
        start_frame(64, 1'b1, 8'h3C);
        wait_bytes(20);
        fast_eth  = 1'b0;
        frame_len = ADDR_W'(5);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_frame(IFG_FAST);
        start_frame(61, 1'b1, 8'h0F);
        finish_frame(IFG_FAST);

        // Abort during data byte 30, then send a clean frame
        start_frame(100, 1'b1, 8'h5A);
        wait_bytes(8 + 31);
        #2;
        rst = 1'b0;
        #1;
        check("abort_tx_start", {31'd0, tx_start}, 0);
        check("abort_tx_data", {24'd0, tx_data}, 0);
        check("abort_rd_addr", {21'd0, rd_addr}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        sb.delete();
        frame_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        start_frame(100, 1'b1, 8'h5A);
        finish_frame(IFG_FAST);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
